// File: rtl/operar_vetores_arbitro_if.sv
// Request/result bundle between two vector requesters, the arbiter and the result consumer.
interface operar_vetores_arbitro_if;
  logic       req0;
  logic       req1;
  logic [1:0] op0;
  logic [1:0] op1;
  logic [2:0] a0;
  logic [2:0] b0;
  logic [2:0] a1;
  logic [2:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic       res_valid;
  logic       res_ready;
  logic       res_id;
  logic [5:0] res_data;
  logic       ocupado;

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, res_ready,
    input  gnt0, gnt1, res_valid, res_id, res_data, ocupado
  );

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, res_ready,
    output gnt0, gnt1, res_valid, res_id, res_data, ocupado
  );
endinterface

// File: rtl/operar_vetores_arbitro.sv
// Round-robin arbiter for two requesters feeding one 3-bit vector operation unit.
// Define OPERAR_VETORES_AND_EN to make op 11 a bitwise AND (otherwise it yields zero).
module operar_vetores_arbitro (
  input logic                     clk,
  input logic                     rst,
  operar_vetores_arbitro_if.slave bus
);

  typedef enum logic [1:0] {StOcioso, StCalc, StEntrega} state_e;

  state_e     r_state;
  logic       r_last;
  logic       r_id;
  logic [1:0] r_op;
  logic [2:0] r_a;
  logic [2:0] r_b;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_valid;
  logic       r_res_id;
  logic [5:0] r_data;
  logic       r_ocupado;

  logic       w_any;
  logic       w_win;
  logic [5:0] w_result;

  assign w_any = bus.req0 | bus.req1;
  // On a tie the requester not granted last wins; otherwise the lone requester wins.
  assign w_win = (bus.req0 & bus.req1) ? ~r_last : bus.req1;

  always_comb begin
    w_result = 6'b000000;
    case (r_op)
      2'b00:   w_result = {3'b000, r_a | r_b};
      2'b01:   w_result = {5'b00000, (|r_a) | (|r_b)};
      2'b10:   w_result = {~r_b, ~r_a};
      default: begin
`ifdef OPERAR_VETORES_AND_EN
        w_result = {3'b000, r_a & r_b};
`else
        w_result = 6'b000000;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StOcioso;
      r_last    <= 1'b1;
      r_id      <= 1'b0;
      r_op      <= 2'b00;
      r_a       <= 3'b000;
      r_b       <= 3'b000;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_valid   <= 1'b0;
      r_res_id  <= 1'b0;
      r_data    <= 6'b000000;
      r_ocupado <= 1'b0;
    end else begin
      unique case (r_state)
        StOcioso: begin
          if (w_any) begin
            r_state   <= StCalc;
            r_id      <= w_win;
            r_last    <= w_win;
            r_op      <= w_win ? bus.op1 : bus.op0;
            r_a       <= w_win ? bus.a1 : bus.a0;
            r_b       <= w_win ? bus.b1 : bus.b0;
            r_gnt0    <= ~w_win;
            r_gnt1    <= w_win;
            r_ocupado <= 1'b1;
          end
        end
        StCalc: begin
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_data   <= w_result;
          r_res_id <= r_id;
          r_valid  <= 1'b1;
          r_state  <= StEntrega;
        end
        StEntrega: begin
          if (bus.res_ready) begin
            r_valid   <= 1'b0;
            r_ocupado <= 1'b0;
            r_state   <= StOcioso;
          end
        end
        default: r_state <= StOcioso;
      endcase
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.res_valid = r_valid;
  assign bus.res_id    = r_res_id;
  assign bus.res_data  = r_data;
  assign bus.ocupado   = r_ocupado;

endmodule

// File: tb/tb_operar_vetores_arbitro.sv
// Self-checking bench for operar_vetores_arbitro: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_operar_vetores_arbitro;

  logic clk = 1'b0;
  logic rst;

  operar_vetores_arbitro_if bus ();

  operar_vetores_arbitro dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model: a job is either absent, being granted, or waiting to be delivered.
  int       m_phase;
  bit       m_last;
  bit       m_cap_id;
  bit [1:0] m_cap_op;
  bit [2:0] m_cap_a;
  bit [2:0] m_cap_b;
  bit       m_gnt0;
  bit       m_gnt1;
  bit       m_valid;
  bit       m_id;
  bit [5:0] m_data;

  int  raise_mode;
  bit  hold_req;
  bit  rand_ready;
  int  gnt_ids[$];
  int  gnt_cyc[$];

  function automatic bit [5:0] vec_op(input bit [1:0] op, input bit [2:0] a, input bit [2:0] b);
    case (op)
      2'd0:    return {3'b000, a | b};
      2'd1:    return (a != 3'd0 || b != 3'd0) ? 6'd1 : 6'd0;
      2'd2:    return {~b, ~a};
      default: begin
`ifdef OPERAR_VETORES_AND_EN
        return {3'b000, a & b};
`else
        return 6'd0;
`endif
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
  endtask

  task automatic model_update();
    bit w;
    cyc++;
    if (rst) begin
      m_phase = 0;
      m_last  = 1'b1;
      m_gnt0  = 1'b0;
      m_gnt1  = 1'b0;
      m_valid = 1'b0;
      m_id    = 1'b0;
      m_data  = 6'd0;
    end else if (m_phase == 0) begin
      if (bus.req0 || bus.req1) begin
        w        = (bus.req0 && bus.req1) ? !m_last : bus.req1;
        m_last   = w;
        m_cap_id = w;
        m_cap_op = w ? bus.op1 : bus.op0;
        m_cap_a  = w ? bus.a1 : bus.a0;
        m_cap_b  = w ? bus.b1 : bus.b0;
        m_gnt0   = !w;
        m_gnt1   = w;
        m_phase  = 1;
      end
    end else if (m_phase == 1) begin
      m_gnt0  = 1'b0;
      m_gnt1  = 1'b0;
      m_valid = 1'b1;
      m_id    = m_cap_id;
      m_data  = vec_op(m_cap_op, m_cap_a, m_cap_b);
      m_phase = 2;
    end else if (bus.res_ready) begin
      m_valid = 1'b0;
      m_phase = 0;
    end
  endtask

  task automatic compare_all();
    chk("gnt0", 32'(bus.gnt0), 32'(m_gnt0));
    chk("gnt1", 32'(bus.gnt1), 32'(m_gnt1));
    chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
    chk("res_id", 32'(bus.res_id), 32'(m_id));
    chk("res_data", 32'(bus.res_data), 32'(m_data));
    chk("ocupado", 32'(bus.ocupado), (m_phase != 0) ? 32'd1 : 32'd0);
    if (bus.gnt0) begin gnt_ids.push_back(0); gnt_cyc.push_back(cyc); end
    if (bus.gnt1) begin gnt_ids.push_back(1); gnt_cyc.push_back(cyc); end
  endtask

  function automatic bit want_raise();
    if (raise_mode == 1) return 1'b1;
    if (raise_mode == 2) return $urandom_range(0, 3) == 0;
    return 1'b0;
  endfunction

  task automatic drive_reqs();
    if (!hold_req) begin
      if (bus.gnt0) bus.req0 = 1'b0;
      else if (!bus.req0 && want_raise()) begin
        bus.req0 = 1'b1;
        bus.op0  = 2'($urandom_range(0, 3));
        bus.a0   = 3'($urandom_range(0, 7));
        bus.b0   = 3'($urandom_range(0, 7));
      end
      if (bus.gnt1) bus.req1 = 1'b0;
      else if (!bus.req1 && want_raise()) begin
        bus.req1 = 1'b1;
        bus.op1  = 2'($urandom_range(0, 3));
        bus.a1   = 3'($urandom_range(0, 7));
        bus.b1   = 3'($urandom_range(0, 7));
      end
    end
    if (rand_ready) bus.res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    drive_reqs();
  endtask

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = 2'd0;  bus.op1 = 2'd0;
    bus.a0 = 3'd0;   bus.b0 = 3'd0;
    bus.a1 = 3'd0;   bus.b1 = 3'd0;
    bus.res_ready = 1'b0;
    raise_mode = 0; hold_req = 1'b0; rand_ready = 1'b0;

    // Pin the operation model to hand-computed values.
    chk("model_or", 32'(vec_op(2'd0, 3'b101, 3'b010)), 32'h07);
    chk("model_inv", 32'(vec_op(2'd2, 3'b001, 3'b100)), 32'h1e);
    chk("model_lor", 32'(vec_op(2'd1, 3'b000, 3'b100)), 32'h01);

    step(); step();
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_data", 32'(bus.res_data), 32'd0);
    chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
    rst = 1'b0;

    // Single request from requester 0, consumer not ready at first.
    bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 3'b101; bus.b0 = 3'b010;
    step();
    chk("t25_gnt0", 32'(bus.gnt0), 32'd1);
    step();
    chk("t25_valid", 32'(bus.res_valid), 32'd1);
    chk("t25_id", 32'(bus.res_id), 32'd0);
    chk("t25_data", 32'(bus.res_data), 32'h07);
    bus.res_ready = 1'b1;
    step();
    chk("t25_done", 32'(bus.res_valid), 32'd0);
    chk("t25_keep", 32'(bus.res_data), 32'h07);

    // Requester 1 alone with ready already high: one-cycle delivery.
    bus.req1 = 1'b1; bus.op1 = 2'b10; bus.a1 = 3'b001; bus.b1 = 3'b100;
    step();
    chk("t26_gnt1", 32'(bus.gnt1), 32'd1);
    step();
    chk("t26_valid", 32'(bus.res_valid), 32'd1);
    chk("t26_data", 32'(bus.res_data), 32'h1e);
    chk("t26_id", 32'(bus.res_id), 32'd1);
    step();
    chk("t26_pulse", 32'(bus.res_valid), 32'd0);
    chk("t26_idle", 32'(bus.ocupado), 32'd0);

    // Op 11 and logical OR of zeros.
    bus.req0 = 1'b1; bus.op0 = 2'b11; bus.a0 = 3'b110; bus.b0 = 3'b011;
    step(); step();
`ifdef OPERAR_VETORES_AND_EN
    chk("t29_and", 32'(bus.res_data), 32'h02);
`else
    chk("t29_and", 32'(bus.res_data), 32'h00);
`endif
    step();
    bus.req0 = 1'b1; bus.op0 = 2'b01; bus.a0 = 3'b000; bus.b0 = 3'b000;
    step(); step();
    chk("t29_lor0", 32'(bus.res_data), 32'h00);
    chk("t29_lor0_v", 32'(bus.res_valid), 32'd1);
    step();

    // Consumer stalls 5 cycles while requester 1 waits.
    bus.res_ready = 1'b0;
    bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 3'b001; bus.b0 = 3'b010;
    step();
    bus.req1 = 1'b1; bus.op1 = 2'b00; bus.a1 = 3'b100; bus.b1 = 3'b000;
    step();
    repeat (5) begin
      step();
      chk("t28_hold_v", 32'(bus.res_valid), 32'd1);
      chk("t28_hold_d", 32'(bus.res_data), 32'h03);
      chk("t28_no_gnt1", 32'(bus.gnt1), 32'd0);
    end
    bus.res_ready = 1'b1;
    step();
    chk("t28_xfer", 32'(bus.res_valid), 32'd0);
    chk("t28_gnt1_late", 32'(bus.gnt1), 32'd0);
    step();
    chk("t28_gnt1", 32'(bus.gnt1), 32'd1);
    step(); step();

    // Both requesters always asking after reset: strict alternation.
    rst = 1'b1;
    step();
    rst = 1'b0;
    gnt_ids.delete(); gnt_cyc.delete();
    raise_mode = 1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    repeat (13) step();
    chk("t27_count", (gnt_ids.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    if (gnt_ids.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t27_order", 32'(gnt_ids[i]), 32'(i % 2));
        if (i > 0) chk("t27_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
      end
    end
    raise_mode = 0;
    repeat (12) step();

    // Reset while calculating, requester 0 keeps asking.
    hold_req = 1'b1;
    bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 3'b001; bus.b0 = 3'b001;
    step();
    chk("t30_gnt0_pre", 32'(bus.gnt0), 32'd1);
    rst = 1'b1;
    step();
    chk("t30_gnt0_rst", 32'(bus.gnt0), 32'd0);
    chk("t30_valid_rst", 32'(bus.res_valid), 32'd0);
    chk("t30_ocup_rst", 32'(bus.ocupado), 32'd0);
    chk("t30_data_rst", 32'(bus.res_data), 32'd0);
    rst = 1'b0;
    hold_req = 1'b0;
    step();
    chk("t30_gnt0_again", 32'(bus.gnt0), 32'd1);
    step();
    chk("t30_data", 32'(bus.res_data), 32'h01);
    step();

    // Randomized traffic with random backpressure and rare resets.
    raise_mode = 2;
    rand_ready = 1'b1;
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/operar_vetores_arbitro.md
OPERAR_VETORES_ARBITRO -- requirements
Module: operar_vetores_arbitro

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports req0/req1, input, 1 bit each: requester 0/1 asks for one vector operation.
REQ-004 SHALL have ports op0/op1, input, 2 bits each: operation code of requester 0/1.
REQ-005 SHALL have ports a0/b0 and a1/b1, input, 3 bits each: operand vectors of requester 0/1.
REQ-006 SHALL have ports gnt0/gnt1, output, 1 bit each: one-cycle pulse meaning the request was accepted.
REQ-007 SHALL have port res_valid, output, 1 bit: res_data/res_id hold a result.
REQ-008 SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-009 SHALL have port res_id, output, 1 bit: the requester that owns the result.
REQ-010 SHALL have port res_data, output, 6 bits: the operation result.
REQ-011 SHALL have port ocupado, output, 1 bit: high whenever the FSM is not in OCIOSO.

Function
REQ-012 SHALL implement the FSM OCIOSO -> CALC -> ENTREGA -> OCIOSO.
REQ-013 In OCIOSO with any req high, SHALL capture the winner's op, a and b and its id at the clock edge, then go to CALC; with no req high it SHALL stay in OCIOSO.
REQ-014 Arbitration SHALL be round-robin:
- only one req high: that requester wins;
- both high: the requester not granted last wins;
- the last-granted pointer updates only on capture.
REQ-015 In CALC, SHALL assert gnt of the captured requester for exactly one cycle, register the result, then go to ENTREGA.
REQ-016 Requesters SHALL hold req and operands until they see gnt, then drop req on the next cycle; the block SHALL rely on this and SHALL NOT re-capture in the same transaction.
REQ-017 Operations, with res_data zero-extended:
- op 00: bitwise OR, {3'b000, a|b};
- op 01: logical OR, {5'b0, (|a)|(|b)};
- op 10: inversion, {~b, ~a};
- op 11: see REQ-024.
REQ-018 In ENTREGA, SHALL hold res_valid high with res_data/res_id stable until a cycle where res_valid and res_ready are both high; after that edge res_valid SHALL be 0 and the FSM SHALL be in OCIOSO.
REQ-019 res_ready already high on entry to ENTREGA SHALL complete the transfer in that single cycle.
REQ-020 Minimum transaction spacing SHALL be 3 cycles; no new capture while res_valid is high.
REQ-021 After a transfer, res_data and res_id SHALL keep their last values while res_valid is 0.

Reset
REQ-022 With rst high at a clock edge, SHALL force:
- state OCIOSO;
- gnt0 = gnt1 = 0, res_valid = 0, res_id = 0, res_data = 6'b000000, ocupado = 0;
- last-granted pointer = 1, so requester 0 wins the first tie.
REQ-023 Reset in CALC or ENTREGA SHALL discard the in-flight operation with no gnt or res_valid for it; req inputs still high after reset SHALL be arbitrated anew.

Configuration
REQ-024 Macro OPERAR_VETORES_AND_EN SHALL select op 11:
- defined: op 11 gives {3'b000, a&b};
- undefined: op 11 gives 6'b000000, still granted and delivered normally.

Verification
REQ-025 req0=1, op0=00, a0=101, b0=010 from idle -> gnt0 pulse 1 cycle after capture; next cycle res_valid=1, res_id=0, res_data=000111.
REQ-026 req1 only, op1=10, a1=001, b1=100, res_ready=1 -> gnt1 pulse; res_data=011110, res_id=1; res_valid high exactly 1 cycle.
REQ-027 req0 and req1 held high from reset, requesters re-raising after each gnt, res_ready=1 -> grant sequence 0,1,0,1 at 3-cycle spacing.
REQ-028 res_ready=0 for 5 cycles in ENTREGA with req1 pending -> res_valid and res_data stable, no gnt1 until the cycle after res_ready=1 completes the transfer.
REQ-029 op0=11, a0=110, b0=011 -> res_data=000010 with OPERAR_VETORES_AND_EN, 000000 without; op0=01, a0=000, b0=000 -> 000000.
REQ-030 rst pulsed during CALC with req0 still high -> after reset all outputs 0, no stale result delivered; req0 re-captured, gnt0 follows.
